// File: rtl/fetch_stage_if.sv
// Decode-side handshake of the fetch stage: head instruction, its PC and valid,
// with decode's ready flowing back.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;

  modport master (
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, reads instruction memory and buffers
// {pc, instr} pairs in a 2-entry FIFO toward decode, with redirect flushing.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_stage_if.master      dec,
  output logic [15:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_STEP_V  = PC_STEP[ADDR_W-1:0];

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  buf_pc    [2];
  logic [INSTR_W-1:0] buf_instr [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               pop;
  logic               push;
  logic               unused_pc_bits;

  // Redirect targets are word aligned, so the low bits are ignored.
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_addr    = pc;
  assign dec.if_valid = (count != 2'd0);
  assign dec.if_instr = buf_instr[rd_ptr];
  assign dec.if_pc    = buf_pc[rd_ptr];

  assign pop  = dec.if_valid & dec.id_ready;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign push = fetch_en & ~redirect_valid & ((count < 2'd2) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC_V;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_count <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]    <= pc;
        buf_instr[wr_ptr] <= imem_rdata;
        wr_ptr            <= ~wr_ptr;
        pc                <= pc + PC_STEP_V;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (fetch_count != '1)
          fetch_count <= fetch_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free run, stall/full, redirect,
// PC wrap, fetch_en gating and reset during operation.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if #(.ADDR_W(8), .INSTR_W(32)) dec_if ();

  fetch_stage #(
    .ADDR_W(8),
    .INSTR_W(32),
    .RESET_PC(0),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec(dec_if),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own address.
  always_comb imem_rdata = 32'h1000_0000 + {24'h0, imem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; dec_if.id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    checks++;
    if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    checks++;
    if (dec_if.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", dec_if.if_valid); end
    checks++;
    if (dec_if.if_instr !== 32'h0 || dec_if.if_pc !== 8'h0) begin
      failures++; $display("FAIL reset_head got instr=%0h pc=%0h exp 0/0", dec_if.if_instr, dec_if.if_pc);
    end
    checks++;
    if (fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    tick();
    checks++;
    if (dec_if.if_valid !== 1'b1 || dec_if.if_pc !== 8'h00 || dec_if.if_instr !== 32'h1000_0000) begin
      failures++;
      $display("FAIL first_fetch got v=%0b pc=%0h instr=%0h exp v=1 pc=0 instr=10000000",
               dec_if.if_valid, dec_if.if_pc, dec_if.if_instr);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (dec_if.if_valid !== 1'b1 || dec_if.if_pc !== 8'(4 * i) ||
          dec_if.if_instr !== 32'h1000_0000 + 32'(4 * i) || fetch_count !== 16'(i)) begin
        failures++;
        $display("FAIL free_run[%0d] got v=%0b pc=%0h instr=%0h cnt=%0d exp v=1 pc=%0h cnt=%0d",
                 i, dec_if.if_valid, dec_if.if_pc, dec_if.if_instr, fetch_count, 4 * i, i);
      end
    end
  endtask

  task automatic test_stall_full();
    rst = 1'b1; dec_if.id_ready = 1'b0; fetch_en = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (imem_addr !== 8'h08) begin failures++; $display("FAIL stall_addr got=%0h exp=08", imem_addr); end
    tick(); tick();
    checks++;
    if (imem_addr !== 8'h08 || dec_if.if_valid !== 1'b1 || dec_if.if_pc !== 8'h00) begin
      failures++;
      $display("FAIL stall_hold got addr=%0h v=%0b pc=%0h exp addr=08 v=1 pc=00",
               imem_addr, dec_if.if_valid, dec_if.if_pc);
    end
    dec_if.id_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (dec_if.if_pc !== 8'(4 * i) || dec_if.if_valid !== 1'b1 || fetch_count !== 16'(i)) begin
        failures++;
        $display("FAIL stall_drain[%0d] got pc=%0h v=%0b cnt=%0d exp pc=%0h v=1 cnt=%0d",
                 i, dec_if.if_pc, dec_if.if_valid, fetch_count, 4 * i, i);
      end
    end
  endtask

  task automatic test_redirect_full();
    rst = 1'b1; dec_if.id_ready = 1'b0; fetch_en = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 8'h43; dec_if.id_ready = 1'b1;
    tick();
    checks++;
    if (dec_if.if_valid !== 1'b0 || imem_addr !== 8'h40 || fetch_count !== 16'h0) begin
      failures++;
      $display("FAIL redirect_flush got v=%0b addr=%0h cnt=%0d exp v=0 addr=40 cnt=0",
               dec_if.if_valid, imem_addr, fetch_count);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (dec_if.if_valid !== 1'b1 || dec_if.if_pc !== 8'h40 || dec_if.if_instr !== 32'h1000_0040) begin
      failures++;
      $display("FAIL redirect_target got v=%0b pc=%0h instr=%0h exp v=1 pc=40 instr=10000040",
               dec_if.if_valid, dec_if.if_pc, dec_if.if_instr);
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dec_if.if_valid !== 1'b1 || dec_if.if_pc !== exp_pc[i] ||
          dec_if.if_instr !== 32'h1000_0000 + {24'h0, exp_pc[i]}) begin
        failures++;
        $display("FAIL pc_wrap[%0d] got v=%0b pc=%0h instr=%0h exp pc=%0h",
                 i, dec_if.if_valid, dec_if.if_pc, dec_if.if_instr, exp_pc[i]);
      end
    end
  endtask

  task automatic test_fetch_en();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dec_if.if_valid !== 1'b0 || imem_addr !== 8'h08) begin
        failures++;
        $display("FAIL fetch_en_hold[%0d] got v=%0b addr=%0h exp v=0 addr=08",
                 i, dec_if.if_valid, imem_addr);
      end
    end
    fetch_en = 1'b1;
    tick();
    checks++;
    if (dec_if.if_valid !== 1'b1 || dec_if.if_pc !== 8'h08 || imem_addr !== 8'h0C) begin
      failures++;
      $display("FAIL fetch_en_resume got v=%0b pc=%0h addr=%0h exp v=1 pc=08 addr=0C",
               dec_if.if_valid, dec_if.if_pc, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    dec_if.id_ready = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 8'h10 || dec_if.if_pc !== 8'h08) begin
      failures++;
      $display("FAIL mid_fill got addr=%0h pc=%0h exp addr=10 pc=08", imem_addr, dec_if.if_pc);
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    checks++;
    if (imem_addr !== 8'h00 || dec_if.if_valid !== 1'b0 || fetch_count !== 16'h0 ||
        dec_if.if_pc !== 8'h00 || dec_if.if_instr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset got addr=%0h v=%0b cnt=%0d pc=%0h instr=%0h exp all zero",
               imem_addr, dec_if.if_valid, fetch_count, dec_if.if_pc, dec_if.if_instr);
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_full();
    test_redirect_full();
    test_pc_wrap();
    test_fetch_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end for the RISC-V core, upstream of decode/control.
- Owns the program counter and drives the instruction-memory read address.
- Captures each returned instruction with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake.
- Accepts branch/jump redirects from the branch adder, flushing in-flight fetches; this lets decode and execute stall without losing instructions.

Parameters:
ADDR_W, 8, PC/instruction-memory address width in bits
INSTR_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
fetch_en  input  1  1 = fetching allowed; 0 = hold PC, no new fetches
imem_addr  output  ADDR_W  instruction-memory read address (= PC register)
imem_rdata  input  INSTR_W  instruction at imem_addr; combinational, same cycle
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  target address for redirect
if_valid  output  1  buffer head holds a valid instruction
if_instr  output  INSTR_W  instruction at buffer head
if_pc  output  ADDR_W  PC of instruction at buffer head
id_ready  input  1  decode accepts head this cycle
fetch_count  output  16  count of instructions accepted by decode; saturating

Behaviour:
- Reset, with rst=1 sampled at a rising edge:
  - pc=RESET_PC, buffer count=0, rd/wr pointers=0, fetch_count=0.
  - Hence imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - Reset overrides every other input in the same cycle.
  - Asserting reset mid-operation discards all buffered instructions.
- State:
  - pc register.
  - 2-entry circular FIFO of {pc, instr} with a count of 0..2.
  - Head/tail pointers of 1 bit each.
- pop = if_valid & id_ready. Head outputs are registered buffer contents; if_valid = (count != 0).
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - A full buffer with a simultaneous pop still pushes; full throughput is 1 instr/cycle.
  - On push: write {pc, imem_rdata} at tail, advance tail, pc <= pc + PC_STEP.
  - PC addition is modulo 2^ADDR_W: 0xFC + 4 wraps to 0x00 with no error.
- Count update: count <= count + push - pop. Count never exceeds 2 and never underflows.
- Redirect has highest priority after reset. When redirect_valid=1:
  - count<=0 and pointers<=0; all buffered entries are flushed, including the current head even if id_ready=1.
  - Pop counts as not accepted: fetch_count is not incremented.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; low two bits are forced to zero, word alignment.
  - No push this cycle.
  - First instruction from the target appears at if_valid one cycle after redirect, assuming fetch_en=1.
- fetch_en=0: pc holds, no push. Pops continue, so the buffer drains. Redirect still updates pc and flushes.
- fetch_count: increments by 1 on each pop with no redirect; saturates at 0xFFFF.
- Latency:
  - PC to if_valid is 1 cycle from an empty buffer.
  - With id_ready held low, the buffer fills within 2 cycles, then pc stalls at the third address.
- Back-to-back: with id_ready=1 and no redirect, if_pc advances by PC_STEP every cycle after the first valid.
- Outputs are stable while if_valid=1 and id_ready=0. The head never changes without a pop or redirect.

Test Plan:
1. Reset then free run: rst 2 cycles, fetch_en=1, id_ready=1, imem returns 0x1000_0000+addr.
   - Required: if_valid rises at cycle 1 after reset with if_pc=0x00, if_instr=0x1000_0000.
   - Then if_pc=0x04, 0x08, ... on consecutive cycles; fetch_count=N after N accepts.
2. Stall/full: id_ready=0 from reset.
   - Required: count reaches 2 and imem_addr holds at 0x08.
   - Head stays pc=0x00 until id_ready=1.
   - Then instrs 0x00, 0x04, 0x08 are delivered in order, none lost or duplicated.
3. Redirect with full buffer: buffer holds 0x00 and 0x04; redirect_valid=1, redirect_pc=0x43, id_ready=1 in the same cycle.
   - Required: next cycle if_valid=0 and imem_addr=0x40; fetch_count unchanged.
   - Following cycle if_pc=0x40.
4. PC wrap: redirect_pc=0xF8, free run.
   - Required: if_pc sequence is 0xF8, 0xFC, 0x00, 0x04.
5. fetch_en gating: deassert fetch_en for 3 cycles with id_ready=1.
   - Required: buffer drains to if_valid=0 and imem_addr is unchanged.
   - Fetching resumes from the same PC when fetch_en=1.
6. Reset mid-operation: assert rst with count=2 and a redirect pending.
   - Required: next cycle pc=RESET_PC, if_valid=0, fetch_count=0.
